// File: rtl/alu_exec_unit_if.sv
// Handshake and operand/result bundle for alu_exec_unit.
// The master drives operations and consumes results. The slave is the execute unit.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a registered result and zero flag, behind valid/ready handshakes.
// By default, shifts step one bit per cycle. Defining ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter instead.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic           clk,
  input logic           rst,
  alu_exec_unit_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;

  state_t             state, state_n;
  logic [WIDTH-1:0]   work, work_n;
  logic [SHAMT_W-1:0] cnt, cnt_n;
  logic               dir_right, dir_right_n;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               out_valid_q;

  logic               in_ready;
  logic               accept;
  logic               is_shift;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_value;
  logic [WIDTH-1:0]   step_value;
  logic               load;
  logic [WIDTH-1:0]   load_value;

  assign in_ready      = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && in_ready;
  assign is_shift      = bus.alu_control[2] && bus.alu_control[1];
  assign shamt         = bus.src_b[SHAMT_W-1:0];
  assign step_value    = dir_right ? (work >> 1) : (work << 1);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

  // Single-cycle datapath. Shifts fall through to src_a, which is also the shift-by-zero result.
  always_comb begin
    alu_value = bus.src_a;
    case (bus.alu_control)
      OP_ADD: alu_value = bus.src_a + bus.src_b;
      OP_SUB: alu_value = bus.src_a - bus.src_b;
      OP_AND: alu_value = bus.src_a & bus.src_b;
      OP_OR:  alu_value = bus.src_a | bus.src_b;
      OP_XOR: alu_value = bus.src_a ^ bus.src_b;
      OP_SLT: alu_value = {{(WIDTH-1){1'b0}},
                           ($signed(bus.src_a) < $signed(bus.src_b))};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: alu_value = bus.src_a << shamt;
      default: alu_value = bus.src_a >> shamt;
`else
      default: alu_value = bus.src_a;
`endif
    endcase
  end

  always_comb begin
    state_n     = state;
    work_n      = work;
    cnt_n       = cnt;
    dir_right_n = dir_right;
    load        = 1'b0;
    load_value  = alu_value;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef ALU_FAST_SHIFT_EN
          load = 1'b1;
`else
          if (is_shift && (shamt != '0)) begin
            work_n      = bus.src_a;
            cnt_n       = shamt;
            dir_right_n = bus.alu_control[0];
            state_n     = SHIFT;
          end else begin
            load = 1'b1;
          end
`endif
        end
      end
      SHIFT: begin
        work_n = step_value;
        cnt_n  = cnt - SHAMT_W'(1);
        // The last step loads its shifted value straight into the result, so latency equals shamt.
        if (cnt == SHAMT_W'(1)) begin
          load       = 1'b1;
          load_value = step_value;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      work        <= '0;
      cnt         <= '0;
      dir_right   <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state     <= state_n;
      work      <= work_n;
      cnt       <= cnt_n;
      dir_right <= dir_right_n;
      if (load) begin
        result_q    <= load_value;
        zero_q      <= (load_value == '0);
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, multi-cycle corner sequences, and randomized ops against a reference model.
module tb_alu_exec_unit;
  localparam int WIDTH = 32;
`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();
  alu_exec_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    int          iter_busy;
  } vec_t;

  vec_t vecs[13];

  // Reference model written straight from the operation definitions
  function automatic logic [31:0] model_result(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] amt;
    amt = b[4:0];
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << amt;
      default: return a >> amt;
    endcase
  endfunction

  function automatic int model_busy(input logic [2:0] c, input logic [31:0] b);
    logic [4:0] amt;
    amt = b[4:0];
    if (FAST || c < 3'd6) return 0;
    return int'(amt);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits for the slot to open, then presents one op for exactly one accept edge. Afterwards it scrambles the inputs.
  task automatic apply_stimulus(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    bus.out_ready = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      tick;
      guard++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", guard);
    end
    bus.in_valid    = 1'b1;
    bus.alu_control = c;
    bus.src_a       = a;
    bus.src_b       = b;
    tick;
    bus.in_valid    = 1'b0;
    bus.alu_control = 3'($urandom);
    bus.src_a       = $urandom;
    bus.src_b       = $urandom;
  endtask

  // Counts result-less cycles after accept, then checks the result, zero and latency.
  task automatic check_output(input string name, input logic [31:0] exp_result, input int exp_busy);
    int busy = 0;
    while (!bus.out_valid && busy < 100) begin
      busy++;
      tick;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got out_valid=0 after %0d cycles, expected 1", name, busy);
    end else begin
      check({name, "_result"}, bus.result, exp_result);
      check({name, "_zero"}, 32'(bus.zero), 32'(exp_result == 32'd0));
      check({name, "_busy"}, 32'(busy), 32'(exp_busy));
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int seen;
    logic [2:0]  rc;
    logic [31:0] ra, rb, rexp;

    vecs[0]  = '{"add",       3'd0, 32'd5,        32'd7,        32'd12,         0};
    vecs[1]  = '{"sub_zero",  3'd1, 32'd7,        32'd7,        32'd0,          0};
    vecs[2]  = '{"and",       3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000,   0};
    vecs[3]  = '{"or",        3'd3, 32'h0F000000, 32'h000000F0, 32'h0F0000F0,   0};
    vecs[4]  = '{"xor",       3'd4, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0,   0};
    vecs[5]  = '{"slt_neg",   3'd5, 32'hFFFFFFFF, 32'd1,        32'd1,          0};
    vecs[6]  = '{"slt_pos",   3'd5, 32'd1,        32'hFFFFFFFF, 32'd0,          0};
    vecs[7]  = '{"add_wrap",  3'd0, 32'hFFFFFFFF, 32'd1,        32'd0,          0};
    vecs[8]  = '{"sub_wrap",  3'd1, 32'd0,        32'd1,        32'hFFFFFFFF,   0};
    vecs[9]  = '{"sll4",      3'd6, 32'h1,        32'h24,       32'h10,         4};
    vecs[10] = '{"srl31",     3'd7, 32'h80000000, 32'd31,       32'h1,          31};
    vecs[11] = '{"sll0",      3'd6, 32'hABCD,     32'h20,       32'hABCD,       0};
    vecs[12] = '{"srl4",      3'd7, 32'hF0000000, 32'd4,        32'h0F000000,   4};

    rst = 1'b1;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.alu_control = 3'd0;
    bus.src_a       = '0;
    bus.src_b       = '0;
    repeat (3) tick;
    rst = 1'b0;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_zero", 32'(bus.zero), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      check_output(vecs[i].name, vecs[i].exp_result, FAST ? 0 : vecs[i].iter_busy);
    end
    tick;

    // Back-to-back add then sub with the consumer always ready
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.alu_control = 3'd0; bus.src_a = 32'd5; bus.src_b = 32'd7;
    tick;
    check("b2b_add_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_add_result", bus.result, 32'd12);
    check("b2b_add_zero", 32'(bus.zero), 32'd0);
    check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    bus.alu_control = 3'd1; bus.src_a = 32'd7; bus.src_b = 32'd7;
    tick;
    bus.in_valid = 1'b0;
    check("b2b_sub_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_sub_result", bus.result, 32'd0);
    check("b2b_sub_zero", 32'(bus.zero), 32'd1);
    tick;
    check("b2b_drain", 32'(bus.out_valid), 32'd0);

    // Backpressure: result must hold and a pending op must wait
    apply_stimulus(3'd4, 32'hF0F0F0F0, 32'hFFFF0000);
    bus.out_ready = 1'b0;
    check_output("bp_xor", 32'h0F0FF0F0, 0);
    bus.in_valid = 1'b1; bus.alu_control = 3'd0; bus.src_a = 32'd1; bus.src_b = 32'd1;
    #1;
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check("bp_hold_result", bus.result, 32'h0F0FF0F0);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick;
    bus.in_valid = 1'b0;
    check("bp_next_result", bus.result, 32'd2);
    check("bp_next_valid", 32'(bus.out_valid), 32'd1);
    tick;
    check("bp_next_drain", 32'(bus.out_valid), 32'd0);

    // Reset taken in the middle of a long shift abandons it
    apply_stimulus(3'd6, 32'd1, 32'd20);
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset_result", bus.result, 32'd0);
    check("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      tick;
      if (bus.out_valid) seen++;
    end
    check("midreset_no_output", 32'(seen), 32'd0);

    // Randomized ops against the reference model, with occasional consumer stalls
    for (int n = 0; n < 150; n++) begin
      rc = 3'($urandom);
      ra = $urandom;
      rb = ($urandom_range(1) == 0) ? 32'($urandom_range(40)) : $urandom;
      rexp = model_result(rc, ra, rb);
      apply_stimulus(rc, ra, rb);
      if ($urandom_range(3) == 0) bus.out_ready = 1'b0;
      check_output("rand", rexp, model_busy(rc, rb));
      if (!bus.out_ready) begin
        for (int k = 0; k < int'($urandom_range(3, 1)); k++) begin
          tick;
          check("rand_hold_result", bus.result, rexp);
          check("rand_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage datapath directly downstream of the ALU control decoder: consumes the 3-bit ALUControl code plus two operands and produces a registered result and zero flag.
- Single-cycle ops: add, sub, and, or, xor, slt. Shifts (sll, srl) are iterative, one bit per cycle.
- Valid/ready handshake on input and output, so the control path stalls while a multi-cycle shift is in progress.

Parameters:
- WIDTH, 32, operand/result width in bits
- SHAMT_W, $clog2(WIDTH), shift-amount width taken from src_b[SHAMT_W-1:0]

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept an operation this cycle
- alu_control  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B / shift amount
- out_valid  output  1  result/zero valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered ALU result
- zero  output  1  result == 0, registered with result

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE, out_valid=0, result=0, zero=0, shift counter=0. This includes a reset taken mid-shift, which abandons the operation with no output.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational, and a result and a new accept can occur in the same cycle.
- Accept = in_valid && in_ready. alu_control, src_a and src_b are sampled only on accept; input changes afterwards are ignored.
- States: IDLE, SHIFT.
- IDLE, accept, non-shift op: next cycle result = op(src_a, src_b), out_valid=1. Latency 1, throughput 1/cycle.
- Arithmetic rules:
  - add/sub wrap modulo 2^WIDTH; no carry/overflow output.
  - slt is signed two's-complement compare, result = {WIDTH-1 zeros, a<b}.
  - srl is logical (zero fill).
- IDLE, accept, sll/srl:
  - Latch src_a into the working register; counter = src_b[SHAMT_W-1:0]. Upper src_b bits are ignored.
  - counter==0: behaves as a 1-cycle op, result = src_a.
  - counter!=0: go to SHIFT, out_valid=0.
- SHIFT: each cycle shift the working register by 1 in the latched direction and decrement counter. When counter reaches 0, load result, set out_valid=1, return to IDLE. Total latency = shamt cycles (min 1). in_ready=0 throughout SHIFT.
- Output hold: while out_valid && !out_ready, result and zero stay stable and no new op is accepted.
- out_valid clears on the handshake (out_valid && out_ready) unless a new op completes in the same edge.
- zero is always computed from the value being loaded into result.
- Unknown/illegal codes do not exist (all 8 encodings are defined).

Optional Feature:
- ALU_FAST_SHIFT_EN
- Defined: sll/srl use a combinational barrel shifter, the SHIFT state is never entered, and every op has latency 1 with in_ready depending only on the output slot.
- Undefined: iterative shifter as described above.

Test Plan:
- Reset mid-shift: start sll with src_a=1, src_b=20, assert rst at cycle 5 -> out_valid=0, result=0, in_ready=1 the cycle after reset deasserts; no result emitted.
- Back-to-back add then sub with out_ready=1: add 5+7, then sub 7-7 on consecutive cycles -> result=12, zero=0, then result=0, zero=1 on consecutive cycles.
- slt signed: src_a=0xFFFFFFFF, src_b=1 -> result=1; swapped -> result=0.
- Iterative sll: src_a=0x1, src_b=0x24 (shamt=4) -> in_ready low 4 cycles, result=0x10 after exactly 4 cycles. srl 0x80000000 by 31 -> result=0x1.
- Backpressure: hold out_ready=0 after xor 0xF0F0F0F0^0xFFFF0000 -> result=0x0F0FF0F0 stable, in_ready=0 until out_ready=1.
- Shift by 0: sll src_a=0xABCD, src_b=0x20 -> result=0xABCD after 1 cycle.
